// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU operand-feed datapath.
// Q8.8 element type, default array size and the row feeder state encoding.
package tpu_pkg;

    localparam int FRAC_BITS = 8;
    localparam int ARRAY_N   = 4;

    typedef logic [15:0] fixed16_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/feeder_row_buf.sv
// N x N tile register file: one row write port, zero-fill clear of all other rows,
// and an N-lane diagonal read at stream cycle rd_t (column-wise with SYSTOLIC_FEEDER_TRANSPOSE_EN).
module feeder_row_buf #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(2*N),
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [N*DATA_W-1:0] wr_row,
    input  logic [CNT_W-1:0]    rd_t,
    output logic [N*DATA_W-1:0] rd_data,
    output logic [N-1:0]        rd_valid
);

    logic [DATA_W-1:0] mem_r [N][N];
    logic [DATA_W-1:0] wr_elem_s [N];

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign wr_elem_s[k] = wr_row[k*DATA_W +: DATA_W];
    end

    // Row storage: the written row wins over the zero-fill clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem_r[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (wr_en && (wr_idx == IDX_W'(r))) begin
                        mem_r[r][c] <= wr_elem_s[c];
                    end else if (clr) begin
                        mem_r[r][c] <= '0;
                    end else begin
                        mem_r[r][c] <= mem_r[r][c];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [CNT_W-1:0] diff_s;
        logic [IDX_W-1:0] row_s;
        logic [IDX_W-1:0] col_s;
        logic             act_s;

        // Lane i sees element t-i of its row (or column) once the skew has reached it
        always_comb begin
            diff_s = rd_t - CNT_W'(i);
            act_s  = (rd_t >= CNT_W'(i)) && (diff_s < CNT_W'(N));
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
            row_s  = diff_s[IDX_W-1:0];
            col_s  = IDX_W'(i);
`else
            row_s  = IDX_W'(i);
            col_s  = diff_s[IDX_W-1:0];
`endif
        end

        // Forward an in-flight write so the first stream cycle can follow the last row directly
        always_comb begin
            rd_valid[i] = act_s;
            if (!act_s) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (wr_en && (wr_idx == row_s)) begin
                rd_data[i*DATA_W +: DATA_W] = wr_elem_s[col_s];
            end else if (clr) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = mem_r[row_s][col_s];
            end
        end
    end

endmodule

// File: rtl/systolic_row_feeder.sv
// Buffers an N x N Q8.8 tile row by row and replays it as a diagonally skewed stream
// for the systolic array. Option: SYSTOLIC_FEEDER_TRANSPOSE_EN selects column-wise skew.
module systolic_row_feeder
    import tpu_pkg::*;
#(
    parameter int N      = ARRAY_N,
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(2*N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_row,
    input  logic                in_last,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [N*DATA_W-1:0] out_data,
    output logic [N-1:0]        out_lane_valid,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(2*N-2);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N-1);

    feeder_state_e      state_r;
    logic [IDX_W-1:0]   row_cnt_r;
    logic [CNT_W-1:0]   t_r;

    logic               accept_s;
    logic               clr_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic [CNT_W-1:0]   rd_t_s;
    logic [N*DATA_W-1:0] rd_data_s;
    logic [N-1:0]       rd_valid_s;

    assign accept_s = in_valid && in_ready;

    // Write addressing and the read cycle that the next registered output will present
    always_comb begin
        clr_s = accept_s && (state_r == ST_IDLE);
        if (state_r == ST_IDLE) begin
            wr_idx_s = '0;
        end else begin
            wr_idx_s = row_cnt_r;
        end
        if (state_r == ST_STREAM) begin
            rd_t_s = t_r + CNT_W'(1);
        end else begin
            rd_t_s = '0;
        end
    end

    feeder_row_buf #(
        .N      (N),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_row_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .wr_en    (accept_s),
        .wr_idx   (wr_idx_s),
        .wr_row   (in_row),
        .rd_t     (rd_t_s),
        .rd_data  (rd_data_s),
        .rd_valid (rd_valid_s)
    );

    // Control FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            row_cnt_r      <= '0;
            t_r            <= '0;
            in_ready       <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_lane_valid <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (accept_s) begin
                        row_cnt_r <= IDX_W'(1);
                        t_r       <= '0;
                        busy      <= 1'b1;
                        if (in_last) begin
                            state_r        <= ST_STREAM;
                            in_ready       <= 1'b0;
                            out_valid      <= 1'b1;
                            out_data       <= rd_data_s;
                            out_lane_valid <= rd_valid_s;
                        end else begin
                            state_r  <= ST_LOAD;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        if (in_last || (row_cnt_r == LAST_ROW)) begin
                            state_r        <= ST_STREAM;
                            in_ready       <= 1'b0;
                            out_valid      <= 1'b1;
                            out_data       <= rd_data_s;
                            out_lane_valid <= rd_valid_s;
                            t_r            <= '0;
                        end else begin
                            row_cnt_r <= row_cnt_r + IDX_W'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    // A low out_ready simply holds every registered output
                    if (out_ready) begin
                        if (t_r == LAST_T) begin
                            state_r        <= ST_DONE;
                            out_valid      <= 1'b0;
                            out_data       <= '0;
                            out_lane_valid <= '0;
                            done           <= 1'b1;
                        end else begin
                            t_r            <= t_r + CNT_W'(1);
                            out_data       <= rd_data_s;
                            out_lane_valid <= rd_valid_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    row_cnt_r <= '0;
                    t_r       <= '0;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    in_ready       <= 1'b0;
                    out_valid      <= 1'b0;
                    out_data       <= '0;
                    out_lane_valid <= '0;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                end
            endcase
        end
    end

endmodule
